rv_insn_encoder: RTL
====================

// Module: rv_insn_encoder
// PURPOSE
//  Inverse of the control unit's decode: assembles 32-bit RV32I instruction words from field commands
//  (format, opcode, funct3/7, registers, immediate) and writes them to instruction memory at consecutive
//  word addresses. Test-program loader / self-test generator ahead of imem; one command -> one word.
// PARAMETERS
//  AW          10   imem word-address width
//  DEPTH       1024 max words per load session (<= 2**AW)
// PORTS
//  clk         in   1   clock, rising edge
//  rst_n       in   1   async active-low reset
//  start       in   1   pulse: begin session at base_addr (ignored unless IDLE or DONE)
//  base_addr   in   AW  first imem word address, sampled on start
//  cmd_valid   in   1   command valid
//  cmd_ready   out  1   command accepted when valid&ready
//  cmd_last    in   1   final command of session
//  cmd_fmt     in   3   000 I, 001 S, 010 B, 011 U, 100 J, 101 R (same codes as control unit ImmSel; R added)
//  cmd_opcode  in   7   opcode[6:0]
//  cmd_funct3  in   3   funct3
//  cmd_funct7  in   7   funct7 (R only)
//  cmd_rd      in   5   rd;  cmd_rs1 in 5 rs1;  cmd_rs2 in 5 rs2
//  cmd_imm     in   32  immediate, byte-offset semantics (B/J as signed offset; U as full value, low 12 dropped)
//  imem_we     out  1   write strobe, held until imem_ready
//  imem_addr   out  AW  write word address
//  imem_wdata  out  32  encoded word
//  imem_ready  in   1   imem accepted write this cycle
//  busy        out  1   state RUN or DRAIN
//  done        out  1   session complete, sticky until start
//  err_fmt     out  1   sticky: cmd_fmt 110/111 accepted
//  err_align   out  1   sticky: B/J with cmd_imm[0]=1
//  word_count  out  AW+1 words written this session
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, internal address 0. Async assert, sync-release use of rst_n.
//  FSM: IDLE -start-> RUN; RUN -accept cmd_last or accept of DEPTH-th cmd-> DRAIN;
//   DRAIN -output reg empty-> DONE; DONE -start-> RUN. start in RUN/DRAIN ignored.
//  start: addr<=base_addr, word_count<=0, done/err_* cleared.
//  cmd_ready = (state==RUN) & (~imem_we | imem_ready); single output register, 1-cycle latency
//   accept -> imem_we/addr/wdata valid next cycle; back-to-back accepts at full rate when imem_ready=1.
//  Output held stable while imem_we & ~imem_ready. word_count increments on imem_we&imem_ready.
//  Address increments per accepted command, wraps 2**AW-1 -> 0 (no error).
//  Encoding (imm=cmd_imm, op=cmd_opcode):
//   I {imm[11:0],rs1,f3,rd,op}          S {imm[11:5],rs2,rs1,f3,imm[4:0],op}
//   B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}   U {imm[31:12],rd,op}
//   J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}         R {f7,rs2,rs1,f3,rd,op}
//  Out-of-range imm bits silently truncated. Illegal fmt: write 32'h0000_0013 (nop), set err_fmt.
//  Misaligned B/J: encode anyway (bit0 dropped), set err_align.
//  Reset mid-session: write strobe drops immediately, pending word lost, state IDLE.
// STRUCTURE
//  Package rv_isa_pkg: fmt codes FMT_I..FMT_R, opcode constants (OP_IMM 0010011, LOAD 0000011,
//   OP 0110011, JAL 1101111, STORE 0100011, LUI 0110111, BRANCH 1100011), NOP word, state enum.
//  Sub-module rv_insn_pack: pure combinational field->word packer (shareable with checker models);
//   top holds FSM, handshake, output register, counters.
// TESTING
//  base 0x010, I addi x1,x0,5 -> imem_addr 0x010, wdata 0x00500093 one cycle after accept.
//  S sw x2,8(x1) -> 0x0020A423; B bne x1,x2,imm=-4 -> 0xFE209EE3; err_align stays 0.
//  U lui x5,imm=0x12345000 -> 0x123452B7; J jal x1,imm=8 -> 0x008000EF; R add x3,x1,x2 -> 0x002081B3.
//  imem_ready low 3 cycles: wdata/addr stable, cmd_ready 0; 6-cmd stream with cmd_last -> done=1, word_count 6.
//  fmt 111 -> wdata 0x00000013, err_fmt=1; B imm=3 -> err_align=1; both cleared by next start.
//  AW=2 base 3, 3 cmds -> addrs 3,0,1; rst_n low mid-stream -> imem_we 0 same cycle, IDLE, start needed.

Source files
------------

// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants shared by the instruction encoder, its packer and checker models.
package rv_isa_pkg;

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_U = 3'b011;
  localparam logic [2:0] FMT_J = 3'b100;
  localparam logic [2:0] FMT_R = 3'b101;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/rv_insn_pack.sv
// Pure combinational RV32I field-to-word packer; flags illegal formats and odd branch/jump offsets.
module rv_insn_pack
  import rv_isa_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        bad_fmt,
  output logic        misaligned
);

  always_comb begin
    word = NOP_WORD;
    unique case (fmt)
      FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
      FMT_U: word = {imm[31:12], rd, opcode};
      FMT_J: word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
      default: word = NOP_WORD;
    endcase
  end

  assign bad_fmt    = (fmt == 3'b110) || (fmt == 3'b111);
  // B/J offsets are halfword multiples; bit 0 is never encoded.
  assign misaligned = ((fmt == FMT_B) || (fmt == FMT_J)) && imm[0];

endmodule

// File: rtl/rv_insn_encoder.sv
// Test-program loader: packs one command per cycle into an RV32I word and writes it to
// consecutive imem addresses through a single registered write port.
module rv_insn_encoder
  import rv_isa_pkg::*;
#(
  parameter int AW    = 10,
  parameter int DEPTH = 1024
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_last,
  input  logic [2:0]    cmd_fmt,
  input  logic [6:0]    cmd_opcode,
  input  logic [2:0]    cmd_funct3,
  input  logic [6:0]    cmd_funct7,
  input  logic [4:0]    cmd_rd,
  input  logic [4:0]    cmd_rs1,
  input  logic [4:0]    cmd_rs2,
  input  logic [31:0]   cmd_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  input  logic          imem_ready,
  output logic          busy,
  output logic          done,
  output logic          err_fmt,
  output logic          err_align,
  output logic [AW:0]   word_count
);

  localparam logic [AW:0]   LAST_IDX = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW-1:0] ADDR_ONE = 1;

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   cmd_cnt_q, cmd_cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] oaddr_q, oaddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [AW:0]   wc_q, wc_d;
  logic          done_q, done_d;
  logic          err_fmt_q, err_fmt_d;
  logic          err_align_q, err_align_d;

  logic [31:0] pack_word;
  logic        pack_bad_fmt;
  logic        pack_misaligned;
  logic        accept;
  logic        wr_fire;
  logic        start_ok;

  rv_insn_pack u_pack (
    .fmt        (cmd_fmt),
    .opcode     (cmd_opcode),
    .funct3     (cmd_funct3),
    .funct7     (cmd_funct7),
    .rd         (cmd_rd),
    .rs1        (cmd_rs1),
    .rs2        (cmd_rs2),
    .imm        (cmd_imm),
    .word       (pack_word),
    .bad_fmt    (pack_bad_fmt),
    .misaligned (pack_misaligned)
  );

  // The output register can take a new word whenever it is empty or being drained this cycle.
  assign cmd_ready = (state_q == ST_RUN) && (!we_q || imem_ready);
  assign accept    = cmd_valid && cmd_ready;
  assign wr_fire   = we_q && imem_ready;
  assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cmd_cnt_d   = cmd_cnt_q;
    we_d        = we_q;
    oaddr_d     = oaddr_q;
    wdata_d     = wdata_q;
    wc_d        = wc_q;
    done_d      = done_q;
    err_fmt_d   = err_fmt_q;
    err_align_d = err_align_q;

    if (wr_fire) begin
      we_d = 1'b0;
      wc_d = wc_q + CNT_ONE;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          state_d     = ST_RUN;
          addr_d      = base_addr;
          cmd_cnt_d   = '0;
          wc_d        = '0;
          done_d      = 1'b0;
          err_fmt_d   = 1'b0;
          err_align_d = 1'b0;
        end
      end
      ST_RUN: begin
        if (accept) begin
          we_d      = 1'b1;
          oaddr_d   = addr_q;
          wdata_d   = pack_word;
          addr_d    = addr_q + ADDR_ONE;
          cmd_cnt_d = cmd_cnt_q + CNT_ONE;
          if (pack_bad_fmt)    err_fmt_d   = 1'b1;
          if (pack_misaligned) err_align_d = 1'b1;
          if (cmd_last || (cmd_cnt_q == LAST_IDX)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!we_q || imem_ready) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cmd_cnt_q   <= '0;
      we_q        <= 1'b0;
      oaddr_q     <= '0;
      wdata_q     <= '0;
      wc_q        <= '0;
      done_q      <= 1'b0;
      err_fmt_q   <= 1'b0;
      err_align_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmd_cnt_q   <= cmd_cnt_d;
      we_q        <= we_d;
      oaddr_q     <= oaddr_d;
      wdata_q     <= wdata_d;
      wc_q        <= wc_d;
      done_q      <= done_d;
      err_fmt_q   <= err_fmt_d;
      err_align_q <= err_align_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = oaddr_q;
  assign imem_wdata = wdata_q;
  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = done_q;
  assign err_fmt    = err_fmt_q;
  assign err_align  = err_align_q;
  assign word_count = wc_q;

endmodule
